// File: rtl/ra_pq_param.sv
// ra_pq_param -- register-array priority queue with sorted storage.
//
// Entries live in a sorted array of DEPTH slots (slot 0 = head). Enqueue,
// dequeue and combined enqueue+dequeue (replace) each complete in one clock.
// Ordering is selectable (smallest or largest key first). Equal keys keep
// arrival order.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   enq          enqueue kvi this cycle
//   deq          dequeue the head this cycle
//   kvi          {key,val} to insert
//   kvo          {key,val} of the current head (registered, 0 when empty)
//   busy         not ready; high during reset and for one cycle after
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   count        number of valid entries
//   ovf          one-cycle pulse: enqueue dropped because the queue was full
//   udf          one-cycle pulse: dequeue requested while the queue was empty
module ra_pq_param #(
   parameter int KEY_WIDTH = 8,
   parameter int VAL_WIDTH = 8,
   parameter int DEPTH     = 8,
   parameter int MIN_FIRST = 1,
   parameter int AF_LEVEL  = DEPTH - 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enq,
   input  logic                              deq,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0]    kvi,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0]    kvo,
   output logic                              busy,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic                              ovf,
   output logic                              udf
);

   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = $clog2(DEPTH);
   localparam int KVW = KEY_WIDTH + VAL_WIDTH;

   typedef enum logic [2:0] {
      OP_IDLE,
      OP_ENQ,
      OP_DEQ,
      OP_REP,
      OP_OVF,
      OP_UDF
   } op_e;

   // Slot storage
   logic [KEY_WIDTH-1:0] key_q [DEPTH];
   logic [KEY_WIDTH-1:0] key_d [DEPTH];
   logic [VAL_WIDTH-1:0] val_q [DEPTH];
   logic [VAL_WIDTH-1:0] val_d [DEPTH];
   logic [DEPTH-1:0]     valid_q, valid_d;

   // Neighbour views: up = slot shifted one toward the tail, dn = toward the head
   logic [KEY_WIDTH-1:0] up_key [DEPTH];
   logic [VAL_WIDTH-1:0] up_val [DEPTH];
   logic [DEPTH-1:0]     up_valid;
   logic [KEY_WIDTH-1:0] dn_key [DEPTH];
   logic [VAL_WIDTH-1:0] dn_val [DEPTH];
   logic [DEPTH-1:0]     dn_valid;

   logic [CW-1:0]  count_q, count_d;
   logic [KVW-1:0] kvo_q, kvo_d;
   logic           busy_q;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           af_q, af_d;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;

   logic [KEY_WIDTH-1:0] new_key;
   logic [VAL_WIDTH-1:0] new_val;
   logic [DEPTH-1:0]     hit;
   logic [PW-1:0]        pos_enq, pos_rep;
   logic                 empty_now, full_now;
   op_e                  op;

   assign new_key   = kvi[KVW-1:VAL_WIDTH];
   assign new_val   = kvi[VAL_WIDTH-1:0];
   assign empty_now = (count_q == '0);
   assign full_now  = (count_q == CW'(DEPTH));

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         // Strictly-better test keeps ties FIFO: a new equal key lands behind
         // every stored equal key.
         if (MIN_FIRST != 0) begin : g_min
            assign hit[gi] = valid_q[gi] && (new_key < key_q[gi]);
         end else begin : g_max
            assign hit[gi] = valid_q[gi] && (new_key > key_q[gi]);
         end

         if (gi == 0) begin : g_up_head
            assign up_key[gi]   = '0;
            assign up_val[gi]   = '0;
            assign up_valid[gi] = 1'b0;
         end else begin : g_up
            assign up_key[gi]   = key_q[gi-1];
            assign up_val[gi]   = val_q[gi-1];
            assign up_valid[gi] = valid_q[gi-1];
         end

         if (gi == DEPTH - 1) begin : g_dn_tail
            assign dn_key[gi]   = '0;
            assign dn_val[gi]   = '0;
            assign dn_valid[gi] = 1'b0;
         end else begin : g_dn
            assign dn_key[gi]   = key_q[gi+1];
            assign dn_val[gi]   = val_q[gi+1];
            assign dn_valid[gi] = valid_q[gi+1];
         end
      end
   endgenerate

   // Request decode; enq+deq on an empty queue degenerates to a plain enqueue.
   always_comb begin
      op = OP_IDLE;
      if (!busy_q) begin
         if (enq && (!deq || empty_now)) begin
            op = full_now ? OP_OVF : OP_ENQ;
         end else if (enq && deq) begin
            op = OP_REP;
         end else if (deq) begin
            op = empty_now ? OP_UDF : OP_DEQ;
         end
      end
   end

   // Insert positions. For a plain enqueue: first hit, else first free slot.
   // For replace: search slots 1.. only, and the position is expressed after
   // the head has been removed (hence i-1, and count-1 as the free slot).
   always_comb begin
      pos_enq = PW'(count_q);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hit[i]) pos_enq = PW'(i);
      end
      pos_rep = PW'(count_q - CW'(1));
      for (int i = DEPTH - 1; i >= 1; i--) begin
         if (hit[i]) pos_rep = PW'(i - 1);
      end
   end

   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         key_d[j]   = key_q[j];
         val_d[j]   = val_q[j];
         valid_d[j] = valid_q[j];
         case (op)
            OP_ENQ: begin
               if (PW'(j) == pos_enq) begin
                  key_d[j]   = new_key;
                  val_d[j]   = new_val;
                  valid_d[j] = 1'b1;
               end else if (PW'(j) > pos_enq) begin
                  key_d[j]   = up_key[j];
                  val_d[j]   = up_val[j];
                  valid_d[j] = up_valid[j];
               end
            end
            OP_DEQ: begin
               key_d[j]   = dn_key[j];
               val_d[j]   = dn_val[j];
               valid_d[j] = dn_valid[j];
            end
            OP_REP: begin
               if (PW'(j) < pos_rep) begin
                  key_d[j]   = dn_key[j];
                  val_d[j]   = dn_val[j];
                  valid_d[j] = dn_valid[j];
               end else if (PW'(j) == pos_rep) begin
                  key_d[j]   = new_key;
                  val_d[j]   = new_val;
                  valid_d[j] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (op == OP_ENQ) count_d = count_q + CW'(1);
      if (op == OP_DEQ) count_d = count_q - CW'(1);
      ovf_d   = (op == OP_OVF);
      udf_d   = (op == OP_UDF);
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
      af_d    = (int'(count_d) >= AF_LEVEL);
      kvo_d   = valid_d[0] ? {key_d[0], val_d[0]} : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b1;
         valid_q <= '0;
         count_q <= '0;
         kvo_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         af_q    <= (AF_LEVEL == 0);
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         busy_q  <= 1'b0;
         valid_q <= valid_d;
         count_q <= count_d;
         kvo_q   <= kvo_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Payload needs no reset; only valid bits define occupancy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < DEPTH; j++) begin
            key_q[j] <= key_d[j];
            val_q[j] <= val_d[j];
         end
      end
   end

   assign kvo         = kvo_q;
   assign busy        = busy_q;
   assign full        = full_q;
   assign empty       = empty_q;
   assign almost_full = af_q;
   assign count       = count_q;
   assign ovf         = ovf_q;
   assign udf         = udf_q;

endmodule

// File: tb/tb_ra_pq_param.sv
module tb_ra_pq_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance A: MIN_FIRST=1
   logic        a_rst = 1'b1, a_enq = 1'b0, a_deq = 1'b0;
   logic [15:0] a_kvi = '0, a_kvo;
   logic        a_busy, a_full, a_empty, a_af, a_ovf, a_udf;
   logic [3:0]  a_count;

   // Instance B: MIN_FIRST=0
   logic        b_rst = 1'b1, b_enq = 1'b0, b_deq = 1'b0;
   logic [15:0] b_kvi = '0, b_kvo;
   logic        b_busy, b_full, b_empty, b_af, b_ovf, b_udf;
   logic [3:0]  b_count;

   ra_pq_param #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(8), .MIN_FIRST(1)) u_min (
      .clk(clk), .rst(a_rst), .enq(a_enq), .deq(a_deq), .kvi(a_kvi), .kvo(a_kvo),
      .busy(a_busy), .full(a_full), .empty(a_empty), .almost_full(a_af),
      .count(a_count), .ovf(a_ovf), .udf(a_udf));

   ra_pq_param #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(8), .MIN_FIRST(0)) u_max (
      .clk(clk), .rst(b_rst), .enq(b_enq), .deq(b_deq), .kvi(b_kvi), .kvo(b_kvo),
      .busy(b_busy), .full(b_full), .empty(b_empty), .almost_full(b_af),
      .count(b_count), .ovf(b_ovf), .udf(b_udf));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_op(input logic e, input logic d, input logic [15:0] kv);
      a_enq = e; a_deq = d; a_kvi = kv;
      step();
      a_enq = 1'b0; a_deq = 1'b0;
      $display("A enq=%0b deq=%0b kvi=%h -> kvo=%h count=%0d ovf=%0b udf=%0b",
               e, d, kv, a_kvo, a_count, a_ovf, a_udf);
   endtask

   task automatic b_op(input logic e, input logic d, input logic [15:0] kv);
      b_enq = e; b_deq = d; b_kvi = kv;
      step();
      b_enq = 1'b0; b_deq = 1'b0;
      $display("B enq=%0b deq=%0b kvi=%h -> kvo=%h count=%0d ovf=%0b udf=%0b",
               e, d, kv, b_kvo, b_count, b_ovf, b_udf);
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      step();
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", a_busy); end
      checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", a_count); end
      checks++; if (a_empty !== 1'b1 || a_full !== 1'b0 || a_af !== 1'b0) begin errors++;
         $display("FAIL reset_flags empty=%b full=%b af=%b exp=1,0,0", a_empty, a_full, a_af); end
      checks++; if (a_kvo !== 16'h0000) begin errors++; $display("FAIL reset_kvo got=%h exp=0000", a_kvo); end
      // Release reset with a request pending: it must be ignored while busy.
      a_rst = 1'b0; b_rst = 1'b0;
      a_enq = 1'b1; a_kvi = 16'h0505;
      #1;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL busy_hold got=%b exp=1", a_busy); end
      step();
      a_enq = 1'b0;
      $display("A reset release -> busy=%b count=%0d", a_busy, a_count);
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL busy_drop got=%b exp=0", a_busy); end
      checks++; if (a_count !== 4'd0 || a_empty !== 1'b1) begin errors++;
         $display("FAIL busy_ignore count=%0d empty=%b exp=0,1", a_count, a_empty); end
   endtask

   task automatic test_basic();
      a_op(1'b1, 1'b0, 16'h080E);
      a_op(1'b1, 1'b0, 16'h0B0B);
      a_op(1'b1, 1'b0, 16'h0909);
      checks++; if (a_kvo !== 16'h080E || a_count !== 4'd3) begin errors++;
         $display("FAIL basic_fill kvo=%h count=%0d exp=080E,3", a_kvo, a_count); end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_kvo !== 16'h0909 || a_count !== 4'd2) begin errors++;
         $display("FAIL basic_deq kvo=%h count=%0d exp=0909,2", a_kvo, a_count); end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_kvo !== 16'h0B0B || a_count !== 4'd1) begin errors++;
         $display("FAIL basic_deq2 kvo=%h count=%0d exp=0B0B,1", a_kvo, a_count); end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_empty !== 1'b1 || a_count !== 4'd0 || a_udf !== 1'b0) begin errors++;
         $display("FAIL basic_drain empty=%b count=%0d udf=%b exp=1,0,0", a_empty, a_count, a_udf); end
   endtask

   task automatic test_ties();
      a_op(1'b1, 1'b0, 16'h0501);
      a_op(1'b1, 1'b0, 16'h0502);
      checks++; if (a_kvo !== 16'h0501) begin errors++; $display("FAIL tie_head got=%h exp=0501", a_kvo); end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_kvo !== 16'h0502) begin errors++; $display("FAIL tie_second got=%h exp=0502", a_kvo); end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL tie_empty got=%b exp=1", a_empty); end
   endtask

   task automatic test_full();
      logic [7:0] k;
      // Insert in descending order to exercise head insertion with shifting.
      for (int i = 8; i >= 1; i--) begin
         k = 8'(i);
         a_op(1'b1, 1'b0, {k, k});
         if (i == 2) begin
            checks++; if (a_af !== 1'b1 || a_full !== 1'b0 || a_count !== 4'd7) begin errors++;
               $display("FAIL af_level af=%b full=%b count=%0d exp=1,0,7", a_af, a_full, a_count); end
         end
      end
      checks++; if (a_full !== 1'b1 || a_count !== 4'd8 || a_kvo !== 16'h0101) begin errors++;
         $display("FAIL full_state full=%b count=%0d kvo=%h exp=1,8,0101", a_full, a_count, a_kvo); end
      a_op(1'b1, 1'b0, 16'h0000);
      checks++; if (a_ovf !== 1'b1 || a_count !== 4'd8 || a_kvo !== 16'h0101 || a_af !== 1'b1) begin errors++;
         $display("FAIL ovf_pulse ovf=%b count=%0d kvo=%h af=%b exp=1,8,0101,1", a_ovf, a_count, a_kvo, a_af); end
      a_op(1'b1, 1'b1, 16'h0C0C);
      checks++; if (a_ovf !== 1'b0 || a_count !== 4'd8 || a_kvo !== 16'h0202) begin errors++;
         $display("FAIL replace_full ovf=%b count=%0d kvo=%h exp=0,8,0202", a_ovf, a_count, a_kvo); end
      for (int i = 3; i <= 8; i++) begin
         k = 8'(i);
         a_op(1'b0, 1'b1, 16'h0000);
         checks++; if (a_kvo !== {k, k}) begin errors++;
            $display("FAIL drain_%0d got=%h exp=%h", i, a_kvo, {k, k}); end
      end
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_kvo !== 16'h0C0C || a_count !== 4'd1) begin errors++;
         $display("FAIL drain_last kvo=%h count=%0d exp=0C0C,1", a_kvo, a_count); end
      a_op(1'b0, 1'b1, 16'h0000);
      a_op(1'b0, 1'b1, 16'h0000);
      checks++; if (a_udf !== 1'b1 || a_empty !== 1'b1) begin errors++;
         $display("FAIL udf_min udf=%b empty=%b exp=1,1", a_udf, a_empty); end
   endtask

   task automatic test_max_first();
      b_op(1'b1, 1'b0, 16'h0303);
      b_op(1'b1, 1'b0, 16'hC801);
      b_op(1'b1, 1'b0, 16'h0707);
      checks++; if (b_kvo !== 16'hC801 || b_count !== 4'd3) begin errors++;
         $display("FAIL max_head kvo=%h count=%0d exp=C801,3", b_kvo, b_count); end
      b_op(1'b0, 1'b1, 16'h0000);
      checks++; if (b_kvo !== 16'h0707) begin errors++; $display("FAIL max_deq1 got=%h exp=0707", b_kvo); end
      b_op(1'b0, 1'b1, 16'h0000);
      checks++; if (b_kvo !== 16'h0303) begin errors++; $display("FAIL max_deq2 got=%h exp=0303", b_kvo); end
      b_op(1'b0, 1'b1, 16'h0000);
      b_op(1'b0, 1'b1, 16'h0000);
      checks++; if (b_udf !== 1'b1 || b_count !== 4'd0) begin errors++;
         $display("FAIL max_udf udf=%b count=%0d exp=1,0", b_udf, b_count); end
      b_op(1'b0, 1'b0, 16'h0000);
      checks++; if (b_udf !== 1'b0) begin errors++; $display("FAIL udf_one_cycle got=%b exp=0", b_udf); end
      b_op(1'b1, 1'b1, 16'h0404);
      checks++; if (b_count !== 4'd1 || b_kvo !== 16'h0404 || b_udf !== 1'b0) begin errors++;
         $display("FAIL rep_empty count=%0d kvo=%h udf=%b exp=1,0404,0", b_count, b_kvo, b_udf); end
      b_op(1'b1, 1'b1, 16'h0909);
      checks++; if (b_count !== 4'd1 || b_kvo !== 16'h0909) begin errors++;
         $display("FAIL rep_newhead count=%0d kvo=%h exp=1,0909", b_count, b_kvo); end
   endtask

   task automatic test_back_to_back();
      a_op(1'b1, 1'b0, 16'h0101);
      a_op(1'b1, 1'b0, 16'h0202);
      checks++; if (a_count !== 4'd2 || a_kvo !== 16'h0101) begin errors++;
         $display("FAIL b2b_fill count=%0d kvo=%h exp=2,0101", a_count, a_kvo); end
      a_op(1'b1, 1'b1, 16'h0303);
      checks++; if (a_count !== 4'd2 || a_kvo !== 16'h0202) begin errors++;
         $display("FAIL b2b_replace count=%0d kvo=%h exp=2,0202", a_count, a_kvo); end
      // Reset lands on an edge that also carries an enq+deq request.
      a_enq = 1'b1; a_deq = 1'b1; a_kvi = 16'h0404; a_rst = 1'b1;
      step();
      a_enq = 1'b0; a_deq = 1'b0; a_rst = 1'b0;
      $display("A reset mid-traffic -> count=%0d busy=%b ovf=%b udf=%b", a_count, a_busy, a_ovf, a_udf);
      checks++; if (a_count !== 4'd0 || a_ovf !== 1'b0 || a_udf !== 1'b0 || a_busy !== 1'b1 || a_kvo !== 16'h0000) begin errors++;
         $display("FAIL midreset count=%0d ovf=%b udf=%b busy=%b kvo=%h exp=0,0,0,1,0000",
                  a_count, a_ovf, a_udf, a_busy, a_kvo); end
      step();
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", a_busy); end
      a_op(1'b1, 1'b0, 16'h0606);
      checks++; if (a_count !== 4'd1 || a_kvo !== 16'h0606) begin errors++;
         $display("FAIL post_reset count=%0d kvo=%h exp=1,0606", a_count, a_kvo); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_full();
      test_max_first();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
